systolic_out_stream: RTL and testbench
======================================

# systolic_out_stream

Receiver for the systolic array result port. Captures each result row (`y0..y3`) qualified by `out_valid` into a small row FIFO. Serializes the rows onto a 32-bit AXI4-Stream master for the PS DMA, two elements per beat, with `tlast` marking the end of each matrix. Throttles the array through its `en` input when the FIFO nears full.

## Interface
- `WIDTH`, 16: element width; must equal the array `WIDTH`.
- `ROWS`, 4: result rows per matrix; sets `tlast` spacing.
- `DEPTH`, 8: FIFO depth in rows; power of two, ≥4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous flush.
- `y0`,`y1`,`y2`,`y3` in `WIDTH` each: signed result row from the array.
- `out_valid` in 1: row valid.
- `arr_en` out 1: drives the array `en`.
- `m_axis_tdata` out `2*WIDTH`: output beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last beat of a matrix.
- `overflow` out 1: sticky; a row was dropped.
- `stall_cnt` out 32: backpressure cycle count; tied to 0 unless the feature is enabled.

## Operation
- Write: when `out_valid` is high and the FIFO is not full, push `{y3,y2,y1,y0}`. When `out_valid` is high and the FIFO is full, drop the row and set `overflow`.
- Read FSM, states IDLE, BEAT0, BEAT1:
  - IDLE → BEAT0 when the FIFO is not empty. Load the head row into the output register and present beat 0.
  - BEAT0 → BEAT1 on handshake (`tvalid && tready`). Present beat 1.
  - BEAT1 → BEAT0 on handshake if another row is available, popping it in the same cycle. Otherwise BEAT1 → IDLE.
- Beat 0 `tdata` = `{y1,y0}`. Beat 1 `tdata` = `{y3,y2}`. `y0` occupies bits `[WIDTH-1:0]`.
- Row counter: 0..ROWS-1. It increments on each BEAT1 handshake and wraps to 0 after ROWS-1. `tlast` = 1 only on BEAT1 while the counter equals ROWS-1.
- Flow control: `arr_en` is registered. It is 0 when FIFO occupancy ≥ DEPTH-2 and 1 otherwise. The 2-row margin absorbs the array's in-flight output.
- Simultaneous push and pop: occupancy is unchanged. Push into a full FIFO in the same cycle as a pop is accepted.
- `clr`:
  - Empties the FIFO and sets the FSM to IDLE.
  - Zeroes the row counter and `stall_cnt`, and clears `overflow`.
  - `tvalid` drops on the next edge. This abandons an in-flight beat; software issues `clr` only between matrices.

## Timing
- Reset values: `arr_en`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `overflow`=0, `stall_cnt`=0. FIFO empty, FSM IDLE, row counter 0.
- Latency: a row pushed at edge N gives `tvalid`=1 with beat 0 after edge N+1, assuming the FIFO was empty and the FSM was IDLE.
- Throughput: one beat per cycle under continuous `tready`. A row every 2 cycles is sustained.
- AXIS rules: while `tvalid && !tready`, `tdata` and `tlast` hold stable. `tvalid` never drops without a handshake, except on `clr` or reset.
- Reset mid-burst: all state returns to reset values immediately (asynchronous assertion). Deassertion is released by the next edge.

## Configuration
- `SYSTOLIC_OUT_STALL_CNT_EN` defined: `stall_cnt` increments each cycle that `tvalid && !tready` holds. It saturates at 0xFFFF_FFFF and clears on `clr`.
- Not defined: no counter logic is built and `stall_cnt` is constant 0.

## Structure
- Package `systolic_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_BEAT0`, `ST_BEAT1`).
  - Default `WIDTH`/`ROWS`/`DEPTH` constants.
  - Row packing width localparam `4*WIDTH`.
- Sub-module `systolic_row_fifo`: synchronous FIFO, `4*WIDTH` wide, `DEPTH` deep, with count, full and empty outputs, and `clr`. The top level holds the FSM, output register, row counter, `arr_en` and the counter.

## Test plan
- Product of A = 1..16 row-major and itself; rows 90/100/110/120 … 426/484/542/600; `tready`=1:
  - 8 beats, first `tdata`=0x0064_005A, last `tdata`=0x0258_021E.
  - `tlast` only on beat 8.
  - `arr_en` stays 1.
- Same rows with `tready` toggling 1,0,1,0:
  - Beats are identical and in order, and `tdata` holds during stalls.
  - With the feature enabled, `stall_cnt` equals the number of cycles with `tvalid` high and `tready` low.
- Rows 11/14/17/20, 35/46/57/68, 59/78/97/116, 0/0/0/0:
  - Second beat is 0x0014_0011.
  - `tlast` is on beat 8, with an all-zero row preceding it.
- `tready`=0 with 10 rows pushed:
  - `arr_en` falls after the 6th push.
  - Rows 9 and 10 are dropped and `overflow`=1.
  - Releasing `tready` yields exactly 16 beats.
- `clr` asserted after 3 beats of a matrix:
  - `tvalid`=0 next cycle and `overflow`=0.
  - The next matrix starts with a row counter of 0, so `tlast` lands on its beat 8.
- `rst_n` low mid-beat: all outputs return to reset values immediately, with no beats emitted after release.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array result streamer.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } st_e;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned ROWS_DEF  = 4;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned ROW_W     = 4 * WIDTH_DEF;

  // Packed row width {y3,y2,y1,y0} for a given element width.
  function automatic int unsigned row_w(input int unsigned w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/systolic_row_fifo.sv
// Row FIFO: power-of-two deep, exposes head and the entry behind it so the
// reader can chain rows without a bubble.
module systolic_row_fifo
  import systolic_pkg::*;
#(
  parameter  int unsigned W     = ROW_W,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  head_o,
  output logic [W-1:0]  next_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok) && !clr_i;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  assign head_o      = mem_q[rd_ptr_q];
  assign next_o      = mem_q[rd_nxt];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/systolic_out_stream.sv
// Captures systolic result rows and serializes them as 2-element AXIS beats.
// Optional stall counter: define SYSTOLIC_OUT_STALL_CNT_EN.
module systolic_out_stream
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   y1,
  input  logic [WIDTH-1:0]   y2,
  input  logic [WIDTH-1:0]   y3,
  input  logic               out_valid,
  output logic               arr_en,
  output logic [2*WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               overflow,
  output logic [31:0]        stall_cnt
);

  localparam int unsigned RW  = row_w(WIDTH);
  localparam int unsigned BW  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  st_e            state_q, state_d;
  logic [BW-1:0]  tdata_q;
  logic           tvalid_q, tlast_q, overflow_q, arr_en_q;
  logic [RCW-1:0] row_cnt_q;

  logic [RW-1:0]  fifo_head, fifo_next;
  logic [CW-1:0]  fifo_cnt, fifo_cnt_nxt;
  logic           fifo_full, fifo_empty;

  logic hs_c, more_c, last_row_c, push_c, drop_c;
  logic pop_c, load_lo_c, load_hi_c, load_nxt_c, go_idle_c, row_inc_c;

  assign hs_c       = tvalid_q && m_axis_tready;
  // The head row stays queued until its second beat is accepted.
  assign more_c     = (fifo_cnt >= CW'(2));
  assign last_row_c = (row_cnt_q == RCW'(ROWS - 1));
  assign push_c     = out_valid && !clr && (!fifo_full || pop_c);
  assign drop_c     = out_valid && !clr && fifo_full && !pop_c;

  systolic_row_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .wdata_i     ({y3, y2, y1, y0}),
    .head_o      (fifo_head),
    .next_o      (fifo_next),
    .count_o     (fifo_cnt),
    .count_nxt_o (fifo_cnt_nxt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (!fifo_empty) state_d = ST_BEAT0;
        ST_BEAT0: if (hs_c)        state_d = ST_BEAT1;
        ST_BEAT1: if (hs_c)        state_d = more_c ? ST_BEAT0 : ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop_c      = 1'b0;
    load_lo_c  = 1'b0;
    load_hi_c  = 1'b0;
    load_nxt_c = 1'b0;
    go_idle_c  = 1'b0;
    row_inc_c  = 1'b0;
    if (!clr) begin
      case (state_q)
        ST_IDLE:  load_lo_c = !fifo_empty;
        ST_BEAT0: load_hi_c = hs_c;
        ST_BEAT1: begin
          pop_c      = hs_c;
          row_inc_c  = hs_c;
          load_nxt_c = hs_c && more_c;
          go_idle_c  = hs_c && !more_c;
        end
        default: ;
      endcase
    end
  end

  // Output register, row counter, overflow and array throttle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      arr_en_q   <= 1'b1;
    end else begin
      arr_en_q <= (fifo_cnt_nxt < CW'(DEPTH - 2));
      if (clr) begin
        tvalid_q   <= 1'b0;
        tlast_q    <= 1'b0;
        row_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (drop_c) overflow_q <= 1'b1;
        if (row_inc_c) row_cnt_q <= last_row_c ? '0 : row_cnt_q + RCW'(1);
        if (load_lo_c) begin
          tdata_q  <= fifo_head[BW-1:0];
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b0;
        end
        if (load_hi_c) begin
          tdata_q <= fifo_head[RW-1:BW];
          tlast_q <= last_row_c;
        end
        if (load_nxt_c) begin
          tdata_q <= fifo_next[BW-1:0];
          tlast_q <= 1'b0;
        end
        if (go_idle_c) begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      end
    end
  end

`ifdef SYSTOLIC_OUT_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clr)                                          stall_d = '0;
    else if (tvalid_q && !m_axis_tready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign arr_en        = arr_en_q;

endmodule

// File: tb/tb_systolic_out_stream.sv
// Directed bench for systolic_out_stream: row table, beat scoreboard, corner sequences.
module tb_systolic_out_stream;

  typedef struct packed {
    logic [15:0] y0, y1, y2, y3;
    logic [31:0] b0, b1;
    logic        last;
  } vec_t;

  logic        clk, rst_n, clr, out_valid;
  logic [15:0] y0, y1, y2, y3;
  logic        arr_en, m_axis_tvalid, m_axis_tlast, overflow;
  logic [31:0] m_axis_tdata, stall_cnt;
  logic        tready, rdy_fix, tog_en, tog_q;

  vec_t        tab [8];
  logic [31:0] cap_d [$];
  logic        cap_l [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          arr_low_cnt = 0;
  logic [31:0] stall_m = 0;
  logic        prev_stall = 0;
  logic [31:0] prev_data = 0;
  logic        prev_last = 0;

  assign tready = tog_en ? tog_q : rdy_fix;

  systolic_out_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .y0            (y0),
    .y1            (y1),
    .y2            (y2),
    .y3            (y3),
    .out_valid     (out_valid),
    .arr_en        (arr_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tog_q = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) tog_q = ~tog_q;
      else        tog_q = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Beat capture, stall-hold check and stall-cycle model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_m    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("hold_tdata", m_axis_tdata, prev_data);
        check("hold_tlast", 32'(m_axis_tlast), 32'(prev_last));
      end
      prev_stall = m_axis_tvalid && !tready && !clr;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && tready && !clr) begin
        cap_d.push_back(m_axis_tdata);
        cap_l.push_back(m_axis_tlast);
      end
      if (clr) stall_m = 0;
      else if (m_axis_tvalid && !tready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      if (!arr_en) arr_low_cnt++;
    end
  end

  task automatic push_row(input int r);
    y0 = tab[r].y0;
    y1 = tab[r].y1;
    y2 = tab[r].y2;
    y3 = tab[r].y3;
    out_valid = 1'b1;
    @(posedge clk);
    #1;
    out_valid = 1'b0;
  endtask

  task automatic wait_beats(input int base, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (cap_d.size() < base + n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(cap_d.size() - base), 32'(n));
  endtask

  task automatic verify(input int base, input int first_row, input int nbeats, input string name);
    for (int i = 0; i < nbeats; i++) begin
      int   r;
      logic [31:0] ed;
      logic el;
      r  = first_row + i / 2;
      ed = (i % 2 == 1) ? tab[r].b1 : tab[r].b0;
      el = (i % 2 == 1) ? tab[r].last : 1'b0;
      if (base + i < cap_d.size()) begin
        check($sformatf("%s_data%0d", name, i), cap_d[base+i], ed);
        check($sformatf("%s_last%0d", name, i), 32'(cap_l[base+i]), 32'(el));
      end
    end
  endtask

  task automatic check_stall(input string name);
`ifdef SYSTOLIC_OUT_STALL_CNT_EN
    check(name, stall_cnt, stall_m);
`else
    check(name, stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    int base;
    int alc;
    //            y0       y1       y2       y3       beat0          beat1          last
    tab[0] = '{16'h005A, 16'h0064, 16'h006E, 16'h0078, 32'h0064_005A, 32'h0078_006E, 1'b0};
    tab[1] = '{16'h00CA, 16'h00E4, 16'h00FE, 16'h0118, 32'h00E4_00CA, 32'h0118_00FE, 1'b0};
    tab[2] = '{16'h013A, 16'h0164, 16'h018E, 16'h01B8, 32'h0164_013A, 32'h01B8_018E, 1'b0};
    tab[3] = '{16'h01AA, 16'h01E4, 16'h021E, 16'h0258, 32'h01E4_01AA, 32'h0258_021E, 1'b1};
    tab[4] = '{16'h000B, 16'h000E, 16'h0011, 16'h0014, 32'h000E_000B, 32'h0014_0011, 1'b0};
    tab[5] = '{16'h0023, 16'h002E, 16'h0039, 16'h0044, 32'h002E_0023, 32'h0044_0039, 1'b0};
    tab[6] = '{16'h003B, 16'h004E, 16'h0061, 16'h0074, 32'h004E_003B, 32'h0074_0061, 1'b0};
    tab[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; clr = 1'b0; out_valid = 1'b0;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    rdy_fix = 1'b1; tog_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arr_en", 32'(arr_en), 32'd1);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Matrix A*A with continuous ready.
    base = cap_d.size();
    alc  = arr_low_cnt;
    for (int r = 0; r < 4; r++) push_row(r);
    wait_beats(base, 8, 100, "t1_count");
    verify(base, 0, 8, "t1");
    check("t1_arr_en_low_cycles", 32'(arr_low_cnt - alc), 32'd0);

    // Same matrix with ready toggling.
    @(posedge clk);
    #2;
    tog_en = 1'b1;
    base = cap_d.size();
    for (int r = 0; r < 4; r++) push_row(r);
    wait_beats(base, 8, 200, "t2_count");
    tog_en = 1'b0;
    verify(base, 0, 8, "t2");
    check_stall("t2_stall_cnt");

    // Second matrix ending in an all-zero row.
    base = cap_d.size();
    for (int r = 4; r < 8; r++) push_row(r);
    wait_beats(base, 8, 100, "t3_count");
    verify(base, 4, 8, "t3");

    // Backpressure: ten rows into an 8-deep FIFO.
    rdy_fix = 1'b0;
    base = cap_d.size();
    for (int i = 0; i < 10; i++) begin
      push_row(i % 8);
      if (i == 4) check("t4_arr_en_after5", 32'(arr_en), 32'd1);
      if (i == 5) check("t4_arr_en_after6", 32'(arr_en), 32'd0);
      if (i == 7) check("t4_overflow_after8", 32'(overflow), 32'd0);
      if (i == 9) check("t4_overflow_after10", 32'(overflow), 32'd1);
    end
    check_stall("t4_stall_held");
    rdy_fix = 1'b1;
    wait_beats(base, 16, 200, "t4_count");
    verify(base, 0, 16, "t4");
    repeat (10) @(posedge clk);
    #1;
    check("t4_exact_beats", 32'(cap_d.size() - base), 32'd16);
    check("t4_arr_en_recovered", 32'(arr_en), 32'd1);
    check("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Flush after three beats, then a fresh matrix.
    base = cap_d.size();
    for (int r = 0; r < 4; r++) push_row(r);
    wait_beats(base, 3, 50, "t5_pre_count");
    clr = 1'b1;
    rdy_fix = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t5_tlast", 32'(m_axis_tlast), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_stall_cnt", stall_cnt, 32'd0);
    check("t5_beats_before_clr", 32'(cap_d.size() - base), 32'd3);
    verify(base, 0, 3, "t5_pre");
    rdy_fix = 1'b1;
    base = cap_d.size();
    for (int r = 4; r < 8; r++) push_row(r);
    wait_beats(base, 8, 100, "t5_count");
    verify(base, 4, 8, "t5");

    // Asynchronous reset while a beat is pending.
    rdy_fix = 1'b0;
    push_row(1);
    repeat (2) @(posedge clk);
    #2;
    check("t6_tvalid_before", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_tdata", m_axis_tdata, 32'd0);
    check("t6_tlast", 32'(m_axis_tlast), 32'd0);
    check("t6_arr_en", 32'(arr_en), 32'd1);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_fix = 1'b1;
    base = cap_d.size();
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_beats", 32'(cap_d.size() - base), 32'd0);
    check("t6_tvalid_after", 32'(m_axis_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
